// File: rtl/issue_decoder.sv
// issue_decoder: FIFO-buffered RV32I decode/issue stage feeding the RS and LSB.
// Define ISSUE_BCAST_BYPASS_EN to add broadcast bypass to operand resolution.
module issue_decoder #(
   parameter int QUEUE_DEPTH = 4,
   parameter int ROB_IDX_W   = 4,
   parameter int N_BCAST     = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rdy,
   input  logic                           rollback,
   input  logic                           inst_valid,
   input  logic [31:0]                    inst,
   input  logic [31:0]                    inst_pc,
   input  logic                           inst_pred_jump,
   output logic                           inst_ready,
   output logic [4:0]                     reg_rs1,
   output logic [4:0]                     reg_rs2,
   input  logic [31:0]                    reg_rs1_val,
   input  logic [31:0]                    reg_rs2_val,
   input  logic [ROB_IDX_W:0]             reg_rs1_tag,
   input  logic [ROB_IDX_W:0]             reg_rs2_tag,
   output logic [ROB_IDX_W-1:0]           rob_rs1_pos,
   output logic [ROB_IDX_W-1:0]           rob_rs2_pos,
   input  logic                           rob_rs1_ready,
   input  logic                           rob_rs2_ready,
   input  logic [31:0]                    rob_rs1_val,
   input  logic [31:0]                    rob_rs2_val,
   input  logic [ROB_IDX_W-1:0]           nxt_rob_pos,
   input  logic                           rob_full,
   input  logic                           rs_full,
   input  logic                           lsb_full,
   input  logic [N_BCAST-1:0]             bcast_valid,
   input  logic [N_BCAST*ROB_IDX_W-1:0]   bcast_rob_pos,
   input  logic [N_BCAST*32-1:0]          bcast_val,
   output logic                           issue,
   output logic                           rs_en,
   output logic                           lsb_en,
   output logic                           is_store,
   output logic                           is_ready,
   output logic [ROB_IDX_W-1:0]           rob_pos,
   output logic [6:0]                     opcode,
   output logic [2:0]                     funct3,
   output logic                           funct7,
   output logic [4:0]                     rd,
   output logic [31:0]                    rs1_val,
   output logic [31:0]                    rs2_val,
   output logic [ROB_IDX_W:0]             rs1_tag,
   output logic [ROB_IDX_W:0]             rs2_tag,
   output logic [31:0]                    imm,
   output logic [31:0]                    pc,
   output logic                           pred_jump
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int TW = ROB_IDX_W + 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(QUEUE_DEPTH);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   logic [31:0]   qinst_q [QUEUE_DEPTH];
   logic [31:0]   qpc_q   [QUEUE_DEPTH];
   logic          qpj_q   [QUEUE_DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [PW:0]   cnt_q;

   logic        head_valid, push, pop, fire, run;
   logic [31:0] hi;
   logic [6:0]  hop;
   logic        known, lsb_sel, mask1, mask2, rd_zero, store;
   logic [31:0] imm_d;
   logic [31:0] rs1_val_d, rs2_val_d;
   logic [TW-1:0] rs1_tag_d, rs2_tag_d;

   logic          issue_q, rs_en_q, lsb_en_q, is_store_q, is_ready_q;
   logic [ROB_IDX_W-1:0] rob_pos_q;
   logic [6:0]    opcode_q;
   logic [2:0]    funct3_q;
   logic          funct7_q, pred_jump_q;
   logic [4:0]    rd_q;
   logic [31:0]   rs1_val_q, rs2_val_q, imm_q, pc_q;
   logic [TW-1:0] rs1_tag_q, rs2_tag_q;

   assign head_valid = (cnt_q != '0);
   assign inst_ready = (cnt_q < DEPTH_C);
   assign run        = rdy && !rollback;
   assign push       = inst_valid && inst_ready && run;
   assign hi         = qinst_q[head_q];
   assign hop        = hi[6:0];

   assign reg_rs1     = head_valid ? hi[19:15] : 5'd0;
   assign reg_rs2     = head_valid ? hi[24:20] : 5'd0;
   assign rob_rs1_pos = head_valid ? reg_rs1_tag[ROB_IDX_W-1:0] : '0;
   assign rob_rs2_pos = head_valid ? reg_rs2_tag[ROB_IDX_W-1:0] : '0;

   always_comb begin
      known   = 1'b1;
      lsb_sel = 1'b0;
      mask1   = 1'b0;
      mask2   = 1'b0;
      rd_zero = 1'b0;
      store   = 1'b0;
      imm_d   = '0;
      unique case (hop)
         OP_LUI, OP_AUIPC: begin
            imm_d = {hi[31:12], 12'b0};
            mask1 = 1'b1;
            mask2 = 1'b1;
         end
         OP_JAL: begin
            imm_d = {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
            mask1 = 1'b1;
            mask2 = 1'b1;
         end
         OP_JALR, OP_IMM: begin
            imm_d = {{20{hi[31]}}, hi[31:20]};
            mask2 = 1'b1;
         end
         OP_LOAD: begin
            imm_d   = {{20{hi[31]}}, hi[31:20]};
            mask2   = 1'b1;
            lsb_sel = 1'b1;
         end
         OP_STORE: begin
            imm_d   = {{20{hi[31]}}, hi[31:25], hi[11:7]};
            rd_zero = 1'b1;
            store   = 1'b1;
            lsb_sel = 1'b1;
         end
         OP_BRANCH: begin
            imm_d   = {{19{hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
            rd_zero = 1'b1;
         end
         OP_OP: imm_d = '0;
         default: known = 1'b0;
      endcase
   end

   // Unknown opcodes drain without waiting for back-end space.
   assign fire = head_valid && run && known && !rob_full &&
                 !(lsb_sel ? lsb_full : rs_full);
   assign pop  = fire || (head_valid && run && !known);

`ifdef ISSUE_BCAST_BYPASS_EN
   function automatic logic [32:0] bcast_lookup(input logic [ROB_IDX_W-1:0] pos);
      bcast_lookup = '0;
      for (int k = N_BCAST-1; k >= 0; k--)
         if (bcast_valid[k] && bcast_rob_pos[k*ROB_IDX_W +: ROB_IDX_W] == pos)
            bcast_lookup = {1'b1, bcast_val[k*32 +: 32]};
   endfunction

   logic [32:0] bh1, bh2;
   assign bh1 = bcast_lookup(reg_rs1_tag[ROB_IDX_W-1:0]);
   assign bh2 = bcast_lookup(reg_rs2_tag[ROB_IDX_W-1:0]);
`else
   logic unused_bcast;
   assign unused_bcast = ^{bcast_valid, bcast_rob_pos, bcast_val};
`endif

   always_comb begin
      rs1_val_d = '0;
      rs1_tag_d = '0;
      if (!reg_rs1_tag[TW-1])  rs1_val_d = reg_rs1_val;
      else if (rob_rs1_ready)  rs1_val_d = rob_rs1_val;
`ifdef ISSUE_BCAST_BYPASS_EN
      else if (bh1[32])        rs1_val_d = bh1[31:0];
`endif
      else                     rs1_tag_d = reg_rs1_tag;
      if (mask1) begin
         rs1_val_d = '0;
         rs1_tag_d = '0;
      end
   end

   always_comb begin
      rs2_val_d = '0;
      rs2_tag_d = '0;
      if (!reg_rs2_tag[TW-1])  rs2_val_d = reg_rs2_val;
      else if (rob_rs2_ready)  rs2_val_d = rob_rs2_val;
`ifdef ISSUE_BCAST_BYPASS_EN
      else if (bh2[32])        rs2_val_d = bh2[31:0];
`endif
      else                     rs2_tag_d = reg_rs2_tag;
      if (mask2) begin
         rs2_val_d = '0;
         rs2_tag_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         qinst_q[tail_q] <= inst;
         qpc_q[tail_q]   <= inst_pc;
         qpj_q[tail_q]   <= inst_pred_jump;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else if (rdy && rollback) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else if (rdy) begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_q     <= 1'b0;
         rs_en_q     <= 1'b0;
         lsb_en_q    <= 1'b0;
         is_store_q  <= 1'b0;
         is_ready_q  <= 1'b0;
         rob_pos_q   <= '0;
         opcode_q    <= '0;
         funct3_q    <= '0;
         funct7_q    <= 1'b0;
         rd_q        <= '0;
         rs1_val_q   <= '0;
         rs2_val_q   <= '0;
         rs1_tag_q   <= '0;
         rs2_tag_q   <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         pred_jump_q <= 1'b0;
      end else begin
         issue_q <= fire;
         if (fire) begin
            rs_en_q     <= !lsb_sel;
            lsb_en_q    <= lsb_sel;
            is_store_q  <= store;
            is_ready_q  <= store;
            rob_pos_q   <= nxt_rob_pos;
            opcode_q    <= hop;
            funct3_q    <= hi[14:12];
            funct7_q    <= hi[30];
            rd_q        <= rd_zero ? 5'd0 : hi[11:7];
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            rs1_tag_q   <= rs1_tag_d;
            rs2_tag_q   <= rs2_tag_d;
            imm_q       <= imm_d;
            pc_q        <= qpc_q[head_q];
            pred_jump_q <= qpj_q[head_q];
         end
      end
   end

   assign issue     = issue_q;
   assign rs_en     = rs_en_q;
   assign lsb_en    = lsb_en_q;
   assign is_store  = is_store_q;
   assign is_ready  = is_ready_q;
   assign rob_pos   = rob_pos_q;
   assign opcode    = opcode_q;
   assign funct3    = funct3_q;
   assign funct7    = funct7_q;
   assign rd        = rd_q;
   assign rs1_val   = rs1_val_q;
   assign rs2_val   = rs2_val_q;
   assign rs1_tag   = rs1_tag_q;
   assign rs2_tag   = rs2_tag_q;
   assign imm       = imm_q;
   assign pc        = pc_q;
   assign pred_jump = pred_jump_q;

endmodule

// File: tb/tb_issue_decoder.sv
// tb_issue_decoder: directed and random checks of issue_decoder
// against a queue-based behavioural model.
module tb_issue_decoder;
   localparam int QD = 4;
   localparam int RW = 4;
   localparam int NB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, rdy, rollback, inst_valid, inst_pred_jump, inst_ready;
   logic [31:0] inst, inst_pc;
   logic [4:0] reg_rs1, reg_rs2;
   logic [31:0] reg_rs1_val, reg_rs2_val, rob_rs1_val, rob_rs2_val;
   logic [RW:0] reg_rs1_tag, reg_rs2_tag;
   logic [RW-1:0] rob_rs1_pos, rob_rs2_pos, nxt_rob_pos;
   logic rob_rs1_ready, rob_rs2_ready, rob_full, rs_full, lsb_full;
   logic [NB-1:0] bcast_valid;
   logic [NB*RW-1:0] bcast_rob_pos;
   logic [NB*32-1:0] bcast_val;
   logic issue, rs_en, lsb_en, is_store, is_ready, funct7, pred_jump;
   logic [RW-1:0] rob_pos;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd;
   logic [31:0] rs1_val, rs2_val, imm, pc;
   logic [RW:0] rs1_tag, rs2_tag;

   issue_decoder #(.QUEUE_DEPTH(QD), .ROB_IDX_W(RW), .N_BCAST(NB)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_pred_jump(inst_pred_jump), .inst_ready(inst_ready),
      .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
      .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
      .reg_rs1_tag(reg_rs1_tag), .reg_rs2_tag(reg_rs2_tag),
      .rob_rs1_pos(rob_rs1_pos), .rob_rs2_pos(rob_rs2_pos),
      .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
      .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
      .nxt_rob_pos(nxt_rob_pos), .rob_full(rob_full),
      .rs_full(rs_full), .lsb_full(lsb_full),
      .bcast_valid(bcast_valid), .bcast_rob_pos(bcast_rob_pos),
      .bcast_val(bcast_val),
      .issue(issue), .rs_en(rs_en), .lsb_en(lsb_en),
      .is_store(is_store), .is_ready(is_ready), .rob_pos(rob_pos),
      .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
      .rs1_val(rs1_val), .rs2_val(rs2_val),
      .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
      .imm(imm), .pc(pc), .pred_jump(pred_jump)
   );

   typedef struct packed {
      logic rs_en, lsb_en, is_store, is_ready;
      logic [RW-1:0] rob_pos;
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic funct7;
      logic [4:0] rd;
      logic [31:0] rs1_val, rs2_val;
      logic [RW:0] rs1_tag, rs2_tag;
      logic [31:0] imm, pc;
      logic pred_jump;
   } iss_t;

   iss_t got;
   assign got = {rs_en, lsb_en, is_store, is_ready, rob_pos, opcode, funct3,
                 funct7, rd, rs1_val, rs2_val, rs1_tag, rs2_tag, imm, pc,
                 pred_jump};

   int checks = 0;
   int errors = 0;
   logic [64:0] mq[$];
   iss_t exp_iss;
   bit exp_issue;

   function automatic void resolve(input logic [RW:0] tag, input logic [31:0] rv,
                                   input logic rr, input logic [31:0] robv,
                                   output logic [RW:0] ot, output logic [31:0] ov);
      bit found;
      found = 0;
      ot = '0;
      ov = '0;
      if (!tag[RW]) ov = rv;
      else if (rr) ov = robv;
      else begin
`ifdef ISSUE_BCAST_BYPASS_EN
         for (int k = 0; k < NB; k++)
            if (!found && bcast_valid[k] && bcast_rob_pos[k*RW +: RW] == tag[RW-1:0]) begin
               ov = bcast_val[k*32 +: 32];
               found = 1;
            end
`endif
         if (!found) ot = tag;
      end
   endfunction

   function automatic bit is_known(input logic [6:0] op);
      return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
   endfunction

   function automatic iss_t predict(input logic [64:0] e);
      iss_t r;
      logic [31:0] i;
      logic [6:0] op;
      bit m1, m2;
      int v;
      i = e[31:0];
      op = i[6:0];
      r = '0;
      v = 0;
      r.lsb_en = (op == 7'h03 || op == 7'h23);
      r.rs_en = !r.lsb_en;
      r.rob_pos = nxt_rob_pos;
      r.opcode = op;
      r.funct3 = i[14:12];
      r.funct7 = i[30];
      r.rd = i[11:7];
      r.pc = e[63:32];
      r.pred_jump = e[64];
      m1 = op inside {7'h37, 7'h17, 7'h6F};
      m2 = m1 || (op inside {7'h67, 7'h03, 7'h13});
      case (op)
         7'h37, 7'h17: v = int'(i[31:12]) * 4096;
         7'h6F: begin
            v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            if (i[31]) v -= 1048576;
         end
         7'h67, 7'h03, 7'h13: begin
            v = int'(i[30:20]);
            if (i[31]) v -= 2048;
         end
         7'h23: begin
            v = int'(i[30:25]) * 32 + int'(i[11:7]);
            if (i[31]) v -= 2048;
            r.rd = 0;
            r.is_store = 1;
            r.is_ready = 1;
         end
         7'h63: begin
            v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            if (i[31]) v -= 4096;
            r.rd = 0;
         end
         default: v = 0;
      endcase
      r.imm = 32'(v);
      if (!m1) resolve(reg_rs1_tag, reg_rs1_val, rob_rs1_ready, rob_rs1_val, r.rs1_tag, r.rs1_val);
      if (!m2) resolve(reg_rs2_tag, reg_rs2_val, rob_rs2_ready, rob_rs2_val, r.rs2_tag, r.rs2_val);
      return r;
   endfunction

   // Advance one clock, updating the model from the inputs held before the edge.
   task automatic step();
      logic [64:0] h;
      bit f, p, ps, lsb;
      f = 0;
      p = 0;
      if (mq.size() > 0 && rdy && !rollback) begin
         h = mq[0];
         lsb = (h[6:0] == 7'h03 || h[6:0] == 7'h23);
         if (!is_known(h[6:0])) p = 1;
         else if (!rob_full && !(lsb ? lsb_full : rs_full)) begin
            f = 1;
            p = 1;
            exp_iss = predict(h);
         end
      end
      ps = inst_valid && mq.size() < QD && rdy && !rollback;
      @(posedge clk);
      if (rdy && rollback) mq.delete();
      else begin
         if (p) void'(mq.pop_front());
         if (ps) mq.push_back({inst_pred_jump, inst_pc, inst});
      end
      exp_issue = f;
      #1;
   endtask

   task automatic idle_inputs();
      rdy = 1; rollback = 0; inst_valid = 0; inst = 0; inst_pc = 0;
      inst_pred_jump = 0; reg_rs1_val = 0; reg_rs2_val = 0;
      reg_rs1_tag = 0; reg_rs2_tag = 0; rob_rs1_ready = 0; rob_rs2_ready = 0;
      rob_rs1_val = 0; rob_rs2_val = 0; nxt_rob_pos = 0; rob_full = 0;
      rs_full = 0; lsb_full = 0; bcast_valid = 0; bcast_rob_pos = 0; bcast_val = 0;
   endtask

   task automatic push_one(input logic [31:0] w, input logic [31:0] p);
      inst_valid = 1;
      inst = w;
      inst_pc = p;
      step();
      inst_valid = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      mq.delete();
      exp_iss = '0;
      exp_issue = 0;
      checks++;
      if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue got %b exp 0", issue); end
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", got); end
      checks++;
      if (inst_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", inst_ready); end
   endtask

   task automatic test_addi();
      push_one(32'h00500093, 32'h100);
      checks++;
      if (issue !== 1'b0) begin errors++; $display("FAIL addi_early got %b exp 0", issue); end
      step();
      checks++;
      if (issue !== 1'b1) begin errors++; $display("FAIL addi_issue got %b exp 1", issue); end
      checks++;
      if ({rs_en, imm, rs1_val, rs2_tag, rd} !== {1'b1, 32'd5, 32'd0, 5'd0, 5'd1}) begin
         errors++;
         $display("FAIL addi_fields got %h exp %h", {rs_en, imm, rs1_val, rs2_tag, rd},
                  {1'b1, 32'd5, 32'd0, 5'd0, 5'd1});
      end
      checks++;
      if (got !== exp_iss) begin errors++; $display("FAIL addi_model got %h exp %h", got, exp_iss); end
      step();
      checks++;
      if (issue !== 1'b0) begin errors++; $display("FAIL addi_once got %b exp 0", issue); end
   endtask

   task automatic test_full_queue();
      int pulses;
      rs_full = 1;
      for (int k = 0; k < QD; k++)
         push_one(32'h00000013 | (32'(k + 1) << 20), 32'h200 + 32'(k * 4));
      checks++;
      if (inst_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", inst_ready); end
      checks++;
      if (issue !== 1'b0) begin errors++; $display("FAIL full_stalled got %b exp 0", issue); end
      rs_full = 0;
      inst_valid = 1;
      inst = 32'h06300093;
      pulses = 0;
      for (int k = 0; k < QD + 1; k++) begin
         step();
         inst_valid = 0;
         if (issue === 1'b1) pulses++;
         checks++;
         if (issue !== exp_issue || (exp_issue && got !== exp_iss)) begin
            errors++;
            $display("FAIL drain_%0d got %b/%h exp %b/%h", k, issue, got, exp_issue, exp_iss);
         end
      end
      checks++;
      if (pulses != QD) begin errors++; $display("FAIL drain_pulses got %0d exp %0d", pulses, QD); end
      checks++;
      if (inst_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", inst_ready); end
   endtask

   task automatic test_bcast();
      push_one(32'h002081B3, 32'h300);
      reg_rs1_tag = 5'h13;
      rob_rs1_ready = 0;
      reg_rs2_tag = 0;
      reg_rs2_val = 32'h7;
      bcast_valid = 2'b10;
      bcast_rob_pos = {4'd3, 4'd0};
      bcast_val = {32'h0000DEAD, 32'h0};
      step();
      checks++;
      if (issue !== 1'b1) begin errors++; $display("FAIL bcast_issue got %b exp 1", issue); end
`ifdef ISSUE_BCAST_BYPASS_EN
      checks++;
      if ({rs1_val, rs1_tag} !== {32'h0000DEAD, 5'h00}) begin
         errors++;
         $display("FAIL bcast_hit got %h/%h exp 0000dead/00", rs1_val, rs1_tag);
      end
`else
      checks++;
      if ({rs1_val, rs1_tag} !== {32'h0, 5'h13}) begin
         errors++;
         $display("FAIL bcast_tag got %h/%h exp 00000000/13", rs1_val, rs1_tag);
      end
`endif
      checks++;
      if (got !== exp_iss) begin errors++; $display("FAIL bcast_model got %h exp %h", got, exp_iss); end
      idle_inputs();
   endtask

   task automatic test_store_stall();
      int pulses;
      push_one(32'hFE512E23, 32'h400);
      lsb_full = 1;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (issue === 1'b1) pulses++;
      end
      lsb_full = 0;
      step();
      checks++;
      if (issue !== 1'b1) begin errors++; $display("FAIL sw_issue got %b exp 1", issue); end
      checks++;
      if ({lsb_en, is_store, is_ready, rd, imm} !== {3'b111, 5'd0, 32'hFFFFFFFC}) begin
         errors++;
         $display("FAIL sw_fields got %h exp %h", {lsb_en, is_store, is_ready, rd, imm},
                  {3'b111, 5'd0, 32'hFFFFFFFC});
      end
      pulses += int'(issue);
      repeat (2) begin
         step();
         if (issue === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL sw_pulses got %0d exp 1", pulses); end
   endtask

   task automatic test_rollback();
      int pulses;
      rs_full = 1;
      for (int k = 0; k < 3; k++) push_one(32'h00100113, 32'h500 + 32'(k * 4));
      rs_full = 0;
      rollback = 1;
      inst_valid = 1;
      inst = 32'h00200113;
      step();
      rollback = 0;
      inst_valid = 0;
      checks++;
      if (issue !== 1'b0) begin errors++; $display("FAIL rb_issue got %b exp 0", issue); end
      pulses = 0;
      repeat (5) begin
         step();
         if (issue === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL rb_stale got %0d exp 0", pulses); end
      rs_full = 1;
      for (int k = 0; k < QD - 1; k++) push_one(32'h00300113, 32'h600);
      checks++;
      if (inst_ready !== 1'b1) begin errors++; $display("FAIL rb_count got %b exp 1", inst_ready); end
      rollback = 1;
      step();
      rollback = 0;
      rs_full = 0;
   endtask

   task automatic test_unknown();
      push_one(32'h0000007F, 32'h700);
      rob_full = 1;
      push_one(32'h12345137, 32'h704);
      rob_full = 0;
      checks++;
      if (issue !== 1'b0) begin errors++; $display("FAIL unk_issue got %b exp 0", issue); end
      step();
      checks++;
      if (issue !== 1'b1) begin errors++; $display("FAIL lui_issue got %b exp 1", issue); end
      checks++;
      if ({imm, rd, rs1_tag, rs1_val, pc} !== {32'h12345000, 5'd2, 5'd0, 32'd0, 32'h704}) begin
         errors++;
         $display("FAIL lui_fields got %h exp %h", {imm, rd, rs1_tag, rs1_val, pc},
                  {32'h12345000, 5'd2, 5'd0, 32'd0, 32'h704});
      end
      step();
   endtask

   task automatic test_rdy_freeze();
      push_one(32'h00A00213, 32'h800);
      rdy = 0;
      repeat (3) begin
         step();
         checks++;
         if (issue !== 1'b0) begin errors++; $display("FAIL frz_issue got %b exp 0", issue); end
      end
      rdy = 1;
      step();
      checks++;
      if (issue !== 1'b1 || got !== exp_iss) begin
         errors++;
         $display("FAIL frz_resume got %b/%h exp 1/%h", issue, got, exp_iss);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [11];
      logic [31:0] w;
      logic [64:0] h;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0F};
      for (int c = 0; c < 600; c++) begin
         rdy = ($urandom_range(0, 9) != 0);
         rollback = ($urandom_range(0, 39) == 0);
         inst_valid = ($urandom_range(0, 3) != 0);
         w = $urandom();
         w[6:0] = ops[$urandom_range(0, 10)];
         inst = w;
         inst_pc = $urandom();
         inst_pred_jump = 1'($urandom_range(0, 1));
         reg_rs1_tag = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
         reg_rs2_tag = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
         reg_rs1_val = $urandom();
         reg_rs2_val = $urandom();
         rob_rs1_ready = 1'($urandom_range(0, 1));
         rob_rs2_ready = 1'($urandom_range(0, 1));
         rob_rs1_val = $urandom();
         rob_rs2_val = $urandom();
         nxt_rob_pos = 4'($urandom_range(0, 15));
         rob_full = ($urandom_range(0, 5) == 0);
         rs_full = ($urandom_range(0, 4) == 0);
         lsb_full = ($urandom_range(0, 4) == 0);
         bcast_valid = 2'($urandom_range(0, 3));
         bcast_rob_pos = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
         bcast_val = {$urandom(), $urandom()};
         step();
         checks++;
         if (issue !== exp_issue || (exp_issue && got !== exp_iss)) begin
            errors++;
            $display("FAIL rand_issue_%0d got %b/%h exp %b/%h", c, issue, got, exp_issue, exp_iss);
         end
         checks++;
         if (inst_ready !== (mq.size() < QD)) begin
            errors++;
            $display("FAIL rand_ready_%0d got %b exp %b", c, inst_ready, mq.size() < QD);
         end
         if (mq.size() > 0) begin
            h = mq[0];
            checks++;
            if ({reg_rs1, reg_rs2} !== {h[19:15], h[24:20]}) begin
               errors++;
               $display("FAIL rand_query_%0d got %h exp %h", c, {reg_rs1, reg_rs2},
                        {h[19:15], h[24:20]});
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_full_queue();
      test_bcast();
      test_store_stall();
      test_rollback();
      test_unknown();
      test_rdy_freeze();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
